// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receive FIFO to its consumer (htif receive port).
// master = producer (FIFO side), slave = consumer.
interface uart_rx_fifo_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small show-ahead FIFO on a valid/ready byte stream.
// The overrun and frame_error outputs are single-cycle registered pulses.
module uart_rx_fifo #(
  parameter int unsigned DIVISOR   = 217,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rxd,
  uart_rx_fifo_if.master rx,
  output logic           overrun,
  output logic           frame_error
);

  localparam int unsigned DEPTH       = 1 << FIFO_LOG2;
  localparam logic [15:0] FULL_RELOAD = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [15:0]          r_timer;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_overrun;
  logic                 r_frame_error;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wr_ptr;
  logic [FIFO_LOG2-1:0] r_rd_ptr;
  logic [FIFO_LOG2:0]   r_count;

  logic w_rxs;
  logic w_sample;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_stop_ok;
  logic w_push;

  assign w_rxs     = r_sync2;
  assign w_sample  = (r_timer == '0);
  assign w_full    = (r_count == (FIFO_LOG2 + 1)'(DEPTH));
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid && rx.rx_ready;
  assign w_stop_ok = (r_state == S_STOP) && w_sample && w_rxs;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push    = w_stop_ok && (!w_full || w_pop);

  assign rx.rx_valid = w_valid;
  assign rx.rx_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign overrun     = r_overrun;
  assign frame_error = r_frame_error;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sync1       <= rxd;
      r_sync2       <= r_sync1;
      r_overrun     <= w_stop_ok && !w_push;
      r_frame_error <= (r_state == S_STOP) && w_sample && !w_rxs;

      if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
        r_timer <= w_sample ? FULL_RELOAD : r_timer - 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_timer <= HALF_RELOAD;
          end
        end
        S_START: begin
          if (w_sample) begin
            r_bit   <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          // Leaving at mid stop bit lets a back-to-back start bit be caught.
          if (w_sample) begin
            r_state <= w_rxs ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (w_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DIVISOR=8, FIFO_LOG2=2: expected bytes
// are queued as frames are driven and checked as the DUT hands them over.
module tb_uart_rx_fifo;

  localparam int DIV = 8;
  // Edge (counted from the first start-bit drive) where the stop bit is sampled:
  // 2 sync flops + 1 idle detect + half bit + 9 full bits.
  localparam int STOP_SAMPLE = 3 + DIV / 2 + 9 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic ovr;
  logic fe;

  uart_rx_fifo_if intf ();

  uart_rx_fifo #(
    .DIVISOR   (DIV),
    .FIFO_LOG2 (2)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .rxd         (rxd),
    .rx          (intf),
    .overrun     (ovr),
    .frame_error (fe)
  );

  always #5 clk = ~clk;

  logic [7:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_spurious = 0;
  int n_ovr = 0;
  int n_fe = 0;
  int n_both = 0;
  int n_long = 0;
  int n_unstable = 0;
  logic p_valid = 1'b0;
  logic p_ready = 1'b0;
  logic p_ovr = 1'b0;
  logic p_fe = 1'b0;
  logic [7:0] p_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (intf.rx_valid && intf.rx_ready) begin
      n_beats++;
      if (sb.size() == 0) begin
        n_spurious++;
      end else begin
        e = sb.pop_front();
        chk("rx_data", {24'b0, intf.rx_data}, {24'b0, e});
      end
    end
    if (ovr) n_ovr++;
    if (fe) n_fe++;
    if (ovr && fe) n_both++;
    if ((ovr && p_ovr) || (fe && p_fe)) n_long++;
    if (p_valid && !p_ready && intf.rx_valid && intf.rx_data !== p_data) n_unstable++;
    p_valid = intf.rx_valid;
    p_ready = intf.rx_ready;
    p_data  = intf.rx_data;
    p_ovr   = ovr;
    p_fe    = fe;
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rxd = stop;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic health(input string t);
    chk({t, " spurious"}, n_spurious, 0);
    chk({t, " pulses together"}, n_both, 0);
    chk({t, " long pulse"}, n_long, 0);
    chk({t, " data unstable"}, n_unstable, 0);
    chk({t, " sb drained"}, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0, o0, f0;
    intf.rx_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid", intf.rx_valid, 0);
    chk("reset rx_data", intf.rx_data, 0);
    chk("reset overrun", ovr, 0);
    chk("reset frame_error", fe, 0);
    rst_n = 1'b1;
    idle(10);

    // Single byte
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    chk("t1 latency beats", n_beats, 1);
    idle(20);
    chk("t1 beats", n_beats, 1);
    chk("t1 overrun", n_ovr, 0);
    chk("t1 frame_error", n_fe, 0);
    health("t1");

    // Burst with backpressure, then overrun
    intf.rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    idle(5);
    chk("t2 rx_valid", intf.rx_valid, 1);
    chk("t2 head", intf.rx_data, 8'h01);
    send_byte(8'h05, 1'b1);
    idle(5);
    chk("t2 overrun", n_ovr, 1);
    chk("t2 head held", intf.rx_data, 8'h01);
    intf.rx_ready = 1'b1;
    idle(10);
    chk("t2 drained valid", intf.rx_valid, 0);
    chk("t2 beats", n_beats, 5);
    health("t2");

    // Full FIFO plus pop at the stop-bit sample
    intf.rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    sb.push_back(8'h05);
    o0 = n_ovr;
    fork
      send_byte(8'h05, 1'b1);
      begin
        repeat (STOP_SAMPLE - 1) @(posedge clk);
        #1 intf.rx_ready = 1'b1;
        @(posedge clk);
        #1 intf.rx_ready = 1'b0;
      end
    join
    idle(5);
    chk("t3 no overrun", n_ovr, o0);
    chk("t3 head", intf.rx_data, 8'h02);
    intf.rx_ready = 1'b1;
    idle(10);
    chk("t3 beats", n_beats, 10);
    chk("t3 drained valid", intf.rx_valid, 0);
    health("t3");

    // Framing error followed by a break
    b0 = n_beats;
    f0 = n_fe;
    o0 = n_ovr;
    send_byte(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(20);
    chk("t4 frame_error", n_fe, f0 + 1);
    chk("t4 overrun", n_ovr, o0);
    chk("t4 no beats", n_beats, b0);
    sb.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    idle(10);
    chk("t4 recovery beats", n_beats, b0 + 1);
    health("t4");

    // Glitch rejection
    b0 = n_beats;
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(30);
    chk("t5 glitch beats", n_beats, b0);
    chk("t5 glitch frame_error", n_fe, f0 + 1);
    chk("t5 glitch overrun", n_ovr, o0);
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(10);
    chk("t5 beats", n_beats, b0 + 1);
    health("t5");

    // Reset mid-frame with bytes buffered
    intf.rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    sb.push_back(8'h22);
    send_byte(8'h22, 1'b1);
    chk("t6 buffered valid", intf.rx_valid, 1);
    rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (4 * DIV) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("t6 reset valid", intf.rx_valid, 0);
    chk("t6 reset data", intf.rx_data, 0);
    b0 = n_beats;
    f0 = n_fe;
    o0 = n_ovr;
    idle(60);
    chk("t6 no frame_error", n_fe, f0);
    chk("t6 no overrun", n_ovr, o0);
    intf.rx_ready = 1'b1;
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(10);
    chk("t6 beats", n_beats, b0 + 1);
    health("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
